// File: rtl/ring_router_sw_alloc_pkg.sv
// Shared constants for the ring router switch allocator: port indices and the
// idle crossbar select. Wormhole locking is built when RING_SWALLOC_LOCK_EN is defined.
package ring_router_sw_alloc_pkg;

  localparam logic [1:0] PORT_PREV = 2'd0;
  localparam logic [1:0] PORT_TERM = 2'd1;
  localparam logic [1:0] PORT_NEXT = 2'd2;

  localparam logic [1:0] SEL_NONE = 2'd0;

  // Increment modulo 3 for the round-robin pointer.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

endpackage

// File: rtl/ring_router_sw_alloc_arb3.sv
// Three-requester round-robin arbiter with its own priority pointer.
// With RING_SWALLOC_LOCK_EN it also holds a wormhole lock to one owner input.
module ring_rr_arb3
  import ring_router_sw_alloc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       en,
`ifdef RING_SWALLOC_LOCK_EN
  input  logic       lock,
  input  logic       unlock,
`endif
  output logic [2:0] grant,
  output logic [1:0] grant_idx
);

  logic [1:0] ptr;
  logic [2:0] req_eff;
  logic [1:0] idx;
  logic       found;
  logic       fire;

`ifdef RING_SWALLOC_LOCK_EN
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0] state;
  logic [1:0] owner;

  // A locked output only listens to its owner.
  always_comb begin
    req_eff = req;
    if (state == ST_LOCKED) req_eff = req & (3'b001 << owner);
  end
`else
  assign req_eff = req;
`endif

  always_comb begin
    grant     = '0;
    grant_idx = SEL_NONE;
    found     = 1'b0;
    idx       = ptr;
    for (int i = 0; i < 3; i++) begin
      if (!found && req_eff[idx]) begin
        found      = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
      idx = inc3(idx);
    end
  end

  assign fire = (|grant) & en;

`ifdef RING_SWALLOC_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= 2'd0;
      state <= ST_IDLE;
      owner <= 2'd0;
    end else if (fire) begin
      if (state == ST_IDLE) begin
        ptr <= inc3(grant_idx);
        if (lock) begin
          state <= ST_LOCKED;
          owner <= grant_idx;
        end
      end else if (unlock) begin
        // Pointer stays frozen for the body of a packet and moves on its tail.
        ptr   <= inc3(grant_idx);
        state <= ST_IDLE;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 2'd0;
    end else if (fire) begin
      ptr <= inc3(grant_idx);
    end
  end
`endif

endmodule

// File: rtl/ring_router_sw_alloc.sv
// Route compute and switch allocation for a bidirectional ring router driving a 3x3 crossbar.
// Define RING_SWALLOC_LOCK_EN to hold an output for a whole packet (wormhole locking).
module ring_router_sw_alloc
  import ring_router_sw_alloc_pkg::*;
#(
  parameter int p_dest_nbits = 2,
  parameter int p_router_id  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    domain,
  input  logic                    in0_val,
  input  logic [p_dest_nbits-1:0] in0_dest,
  input  logic                    in0_tail,
  output logic                    in0_rdy,
  input  logic                    in1_val,
  input  logic [p_dest_nbits-1:0] in1_dest,
  input  logic                    in1_tail,
  output logic                    in1_rdy,
  input  logic                    in2_val,
  input  logic [p_dest_nbits-1:0] in2_dest,
  input  logic                    in2_tail,
  output logic                    in2_rdy,
  output logic                    out0_val,
  input  logic                    out0_rdy,
  output logic                    out1_val,
  input  logic                    out1_rdy,
  output logic                    out2_val,
  input  logic                    out2_rdy,
  output logic [1:0]              sel0,
  output logic [1:0]              sel1,
  output logic [1:0]              sel2
);

  localparam int                      N    = 1 << p_dest_nbits;
  localparam logic [p_dest_nbits-1:0] ID   = p_dest_nbits'(p_router_id);
  localparam logic [p_dest_nbits-1:0] HALF = p_dest_nbits'(N / 2);

  logic [2:0]              val;
  logic [2:0]              tail;
  logic [2:0]              out_rdy_v;
  logic [2:0]              out_val_v;
  logic [2:0]              in_rdy_v;
  logic [2:0]              fire;
  logic [p_dest_nbits-1:0] dest      [3];
  logic [1:0]              route     [3];
  logic [2:0]              req       [3];
  logic [2:0]              grant     [3];
  logic [1:0]              grant_idx [3];

  assign val       = {in2_val, in1_val, in0_val};
  assign tail      = {in2_tail, in1_tail, in0_tail};
  assign out_rdy_v = {out2_rdy, out1_rdy, out0_rdy};
  assign dest[0]   = in0_dest;
  assign dest[1]   = in1_dest;
  assign dest[2]   = in2_dest;

  // Shortest way round the ring; the exact half-way distance goes forward.
  for (genvar j = 0; j < 3; j++) begin : g_route
    logic [p_dest_nbits-1:0] fwd;
    assign fwd      = dest[j] - ID;
    assign route[j] = (dest[j] == ID) ? PORT_TERM :
                      (fwd <= HALF)   ? PORT_NEXT : PORT_PREV;
  end

  for (genvar k = 0; k < 3; k++) begin : g_out
    for (genvar j = 0; j < 3; j++) begin : g_req
      assign req[k][j] = !reset && val[j] && (route[j] == 2'(k));
    end

`ifdef RING_SWALLOC_LOCK_EN
    logic wtail;
    assign wtail = tail[grant_idx[k]];
`endif

    ring_rr_arb3 u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (req[k]),
      .en        (out_rdy_v[k]),
`ifdef RING_SWALLOC_LOCK_EN
      .lock      (!wtail),
      .unlock    (wtail),
`endif
      .grant     (grant[k]),
      .grant_idx (grant_idx[k])
    );

    assign out_val_v[k] = |grant[k];
    assign fire[k]      = out_val_v[k] & out_rdy_v[k];
  end

  always_comb begin
    in_rdy_v = '0;
    for (int k = 0; k < 3; k++) begin
      if (fire[k]) in_rdy_v = in_rdy_v | grant[k];
    end
  end

  assign {in2_rdy, in1_rdy, in0_rdy}    = in_rdy_v;
  assign {out2_val, out1_val, out0_val} = out_val_v;
  assign sel0 = grant_idx[0];
  assign sel1 = grant_idx[1];
  assign sel2 = grant_idx[2];

  // The domain label only tags the data; tails are unused when locking is off.
  logic unused_in;
`ifdef RING_SWALLOC_LOCK_EN
  assign unused_in = domain;
`else
  assign unused_in = ^{domain, tail};
`endif

endmodule

// File: tb/tb_ring_router_sw_alloc.sv
// Bench for ring_router_sw_alloc (router id 1, ring of 4): directed scenarios plus random traffic
// against a behavioural allocator model; follows RING_SWALLOC_LOCK_EN like the design.
`timescale 1ns/1ps
module tb_ring_router_sw_alloc;

  localparam int DN = 2;
  localparam int N  = 4;
  localparam int ID = 1;

  localparam logic [11:0] M_ALL = 12'hFFF;
  localparam logic [11:0] M_VAL = 12'hE00;
  localparam logic [11:0] M_RDY = 12'h1C0;
  localparam logic [11:0] M_S2  = 12'h030;
  localparam logic [11:0] M_S1  = 12'h00C;
  localparam logic [11:0] M_S0  = 12'h003;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic domain = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    val  = '0;
  logic [2:0]    tail = '0;
  logic [2:0]    ordy = '0;
  logic [DN-1:0] dst [3];

  logic in0_rdy, in1_rdy, in2_rdy;
  logic out0_val, out1_val, out2_val;
  logic [1:0] sel0, sel1, sel2;

  ring_router_sw_alloc #(.p_dest_nbits(DN), .p_router_id(ID)) dut (
    .clk      (clk),
    .reset    (reset),
    .domain   (domain),
    .in0_val  (val[0]), .in0_dest (dst[0]), .in0_tail (tail[0]), .in0_rdy (in0_rdy),
    .in1_val  (val[1]), .in1_dest (dst[1]), .in1_tail (tail[1]), .in1_rdy (in1_rdy),
    .in2_val  (val[2]), .in2_dest (dst[2]), .in2_tail (tail[2]), .in2_rdy (in2_rdy),
    .out0_val (out0_val), .out0_rdy (ordy[0]),
    .out1_val (out1_val), .out1_rdy (ordy[1]),
    .out2_val (out2_val), .out2_rdy (ordy[2]),
    .sel0     (sel0),
    .sel1     (sel1),
    .sel2     (sel2)
  );

  // ---------------- scoreboard / model ----------------
  logic [11:0] exp_q[$];
  logic [11:0] last_got;
  int vectors     = 0;
  int miscompares = 0;

  int ptr   [3];
  bit locked[3];
  int owner [3];

  function automatic int route_of(input int d);
    int fwd;
    if (d == ID) return 1;
    fwd = ((d - ID) % N + N) % N;
    return (fwd <= N / 2) ? 2 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      ptr[k] = 0; locked[k] = 1'b0; owner[k] = 0;
    end
  endtask

  task automatic compare_out(input logic [11:0] got);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: no expected entry at vector %0d", vectors);
      return;
    end
    e = exp_q.pop_front();
    if (got !== e) begin
      miscompares++;
      $display("FAIL outputs vec %0d: got val=%b rdy=%b sel2/1/0=%0d/%0d/%0d want val=%b rdy=%b sel2/1/0=%0d/%0d/%0d",
               vectors, got[11:9], got[8:6], got[5:4], got[3:2], got[1:0],
               e[11:9], e[8:6], e[5:4], e[3:2], e[1:0]);
    end
  endtask

  task automatic check_lit(input string name, input logic [11:0] exp, input logic [11:0] mask);
    if ((last_got & mask) !== (exp & mask)) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (field mask %h)", name, last_got & mask, exp & mask, mask);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [2:0] v, input logic [1:0] d0, input logic [1:0] d1,
                      input logic [1:0] d2, input logic [2:0] t, input logic [2:0] r,
                      input logic rst);
    int          win[3];
    logic [2:0]  fv, rv;
    logic [1:0]  sv[3];
    int          j;
    @(negedge clk);
    val = v; dst[0] = d0; dst[1] = d1; dst[2] = d2;
    tail = t; ordy = r; reset = rst; domain = 1'($urandom_range(0, 1));
    #1;
    fv = '0; rv = '0;
    for (int k = 0; k < 3; k++) begin
      win[k] = -1; sv[k] = 2'd0;
      if (!rst) begin
        for (int i = 0; i < 3; i++) begin
          j = (ptr[k] + i) % 3;
          if (win[k] < 0 && v[j] && route_of(int'(dst[j])) == k && (!locked[k] || owner[k] == j))
            win[k] = j;
        end
      end
      if (win[k] >= 0) begin
        fv[k] = 1'b1;
        sv[k] = 2'(win[k]);
        if (r[k]) rv[win[k]] = 1'b1;
      end
    end
    exp_q.push_back({fv, rv, sv[2], sv[1], sv[0]});
    last_got = {out2_val, out1_val, out0_val, in2_rdy, in1_rdy, in0_rdy, sel2, sel1, sel0};
    compare_out(last_got);
    vectors++;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (win[k] >= 0 && r[k]) begin
`ifdef RING_SWALLOC_LOCK_EN
          if (locked[k]) begin
            if (t[win[k]]) begin
              locked[k] = 1'b0;
              ptr[k] = (win[k] + 1) % 3;
            end
          end else begin
            ptr[k] = (win[k] + 1) % 3;
            if (!t[win[k]]) begin
              locked[k] = 1'b1;
              owner[k] = win[k];
            end
          end
`else
          ptr[k] = (win[k] + 1) % 3;
`endif
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] t0_seq;
    logic [1:0] pkt_sel [4];
    dst[0] = '0; dst[1] = '0; dst[2] = '0;
    model_reset();

    step(3'b111, 2'd1, 2'd1, 2'd1, 3'b000, 3'b111, 1'b1);
    step(3'b111, 2'd1, 2'd1, 2'd1, 3'b000, 3'b111, 1'b1);
    check_lit("reset_quiet", 12'h000, M_ALL);

    // Route compute from router 1.
    step(3'b010, 2'd0, 2'd1, 2'd0, 3'b111, 3'b111, 1'b0);
    check_lit("route_dest1_val", {3'b010, 9'd0}, M_VAL);
    check_lit("route_dest1_sel", {8'd0, 2'd1, 2'd0}, M_S1);
    step(3'b010, 2'd0, 2'd2, 2'd0, 3'b111, 3'b111, 1'b0);
    check_lit("route_dest2_val", {3'b100, 9'd0}, M_VAL);
    check_lit("route_dest2_sel", {6'd0, 2'd1, 4'd0}, M_S2);
    step(3'b010, 2'd0, 2'd3, 2'd0, 3'b111, 3'b111, 1'b0);
    check_lit("route_dest3_tie", {3'b100, 9'd0}, M_VAL);
    step(3'b010, 2'd0, 2'd0, 2'd0, 3'b111, 3'b111, 1'b0);
    check_lit("route_dest0_val", {3'b001, 9'd0}, M_VAL);
    check_lit("route_dest0_sel", {10'd0, 2'd1}, M_S0);

    // Three-way contention on out1, first stalled, then flowing.
    step(3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 3'b000, 1'b1);
    for (int c = 0; c < 2; c++) begin
      step(3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 3'b000, 1'b0);
      check_lit("stall_out1", {3'b010, 3'b000, 2'd0, 2'd0, 2'd0}, M_ALL);
    end
    step(3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 3'b010, 1'b0);
    check_lit("rr_grant0", {3'b010, 3'b001, 2'd0, 2'd0, 2'd0}, M_ALL);
    step(3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 3'b010, 1'b0);
    check_lit("rr_grant1", {3'b010, 3'b010, 2'd0, 2'd1, 2'd0}, M_ALL);
    step(3'b111, 2'd1, 2'd1, 2'd1, 3'b111, 3'b010, 1'b0);
    check_lit("rr_grant2", {3'b010, 3'b100, 2'd0, 2'd2, 2'd0}, M_ALL);

    // Opposite-direction traffic fires in parallel.
    step(3'b101, 2'd3, 2'd0, 2'd0, 3'b111, 3'b111, 1'b0);
    check_lit("dual_fire", {3'b101, 3'b101, 2'd0, 2'd0, 2'd2}, M_ALL);

    // Three-flit packet from in0 competing with single flits from in2.
    step(3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 3'b000, 1'b1);
    t0_seq = 3'b100;
`ifdef RING_SWALLOC_LOCK_EN
    pkt_sel[0] = 2'd0; pkt_sel[1] = 2'd0; pkt_sel[2] = 2'd0; pkt_sel[3] = 2'd2;
`else
    pkt_sel[0] = 2'd0; pkt_sel[1] = 2'd2; pkt_sel[2] = 2'd0; pkt_sel[3] = 2'd2;
`endif
    for (int c = 0; c < 4; c++) begin
      step(3'b101, 2'd1, 2'd0, 2'd1, {1'b1, 1'b0, (c < 3) ? t0_seq[c] : 1'b0}, 3'b010, 1'b0);
      check_lit($sformatf("packet_sel1_c%0d", c), {8'd0, pkt_sel[c], 2'd0}, M_S1);
    end

    // Reset in the middle of a packet.
    step(3'b000, 2'd0, 2'd0, 2'd0, 3'b000, 3'b000, 1'b1);
    step(3'b101, 2'd1, 2'd0, 2'd1, 3'b100, 3'b010, 1'b0);
    check_lit("midpkt_first", {8'd0, 2'd0, 2'd0}, M_S1);
    step(3'b101, 2'd1, 2'd0, 2'd1, 3'b100, 3'b010, 1'b1);
    check_lit("midpkt_reset_quiet", 12'h000, M_ALL);
    step(3'b100, 2'd0, 2'd0, 2'd1, 3'b100, 3'b010, 1'b0);
    check_lit("after_reset_in2", {3'b010, 3'b100, 2'd0, 2'd2, 2'd0}, M_ALL);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      step(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 49) == 0));
    end

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
